psum_accumulator: RTL

- Temporal accumulation stage directly downstream of su_adder_v1, the spatial adder tree built from basic_adder elements.
- Consumes one reduced partial sum per accepted beat and adds cfg_len consecutive beats into one output word.
- Presents the finished sum to the output buffer over a valid/ready handshake.
- Arithmetic is modulo 2^DATA_BITWIDTH, so it matches the adder tree exactly.

---
 rtl/psum_accumulator_pkg.sv | 23 ++
 rtl/basic_adder.sv | 31 +++
 rtl/psum_accumulator.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/psum_accumulator_pkg.sv
// psum_accumulator_pkg
//   Shared definitions for the temporal partial-sum accumulator:
//   - datapath width defaults (common with su_adder_v1)
//   - FSM state encoding
//   - basic_adder mode encodings used by the accumulator
package psum_accumulator_pkg;

    localparam int unsigned DEFAULT_DATA_BITWIDTH = 16;
    localparam int unsigned DEFAULT_CNT_BITWIDTH  = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StAccum = 2'b01,
        StHold  = 2'b10
    } acc_state_e;

    // basic_adder operation select
    localparam logic [1:0] ADD_MODE_ZERO       = 2'b00;
    localparam logic [1:0] ADD_MODE_PASS_RIGHT = 2'b01;
    localparam logic [1:0] ADD_MODE_SUM        = 2'b10;
    localparam logic [1:0] ADD_MODE_PASS_LEFT  = 2'b11;

endpackage

// File: rtl/basic_adder.sv
// basic_adder
//   Two-input modulo-2^DATA_BITWIDTH adder element with an operation select,
//   shared with the su_adder_v1 adder tree.
// Ports:
//   left  - first operand
//   right - second operand
//   mode  - 00: zero, 01: pass right, 10: left+right, 11: pass left
//   sum   - result, carry discarded
module basic_adder
    import psum_accumulator_pkg::*;
#(
    parameter int unsigned DATA_BITWIDTH = DEFAULT_DATA_BITWIDTH
) (
    input  logic [DATA_BITWIDTH-1:0] left,
    input  logic [DATA_BITWIDTH-1:0] right,
    input  logic [1:0]               mode,
    output logic [DATA_BITWIDTH-1:0] sum
);

    always_comb begin
        sum = '0;
        unique case (mode)
            ADD_MODE_ZERO:       sum = '0;
            ADD_MODE_PASS_RIGHT: sum = right;
            ADD_MODE_SUM:        sum = left + right;
            ADD_MODE_PASS_LEFT:  sum = left;
            default:             sum = '0;
        endcase
    end

endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator
//   Temporal accumulation stage after the su_adder_v1 spatial adder tree.
//   Adds cfg_len consecutive accepted partial sums (modulo 2^DATA_BITWIDTH)
//   and presents the result over a valid/ready handshake.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   clear     - synchronous abort of any group in progress
//   cfg_len   - beats per output, sampled on the first beat; 0 means 1
//   in_valid  - in_data valid
//   in_ready  - beat can be accepted this cycle
//   in_data   - partial sum from the adder tree
//   out_valid - out_data holds a completed sum
//   out_ready - consumer accepts out_data
//   out_data  - accumulated sum (0 when not valid)
//   busy      - FSM is in ACCUM or HOLD
module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter int unsigned DATA_BITWIDTH = DEFAULT_DATA_BITWIDTH,
    parameter int unsigned CNT_BITWIDTH  = DEFAULT_CNT_BITWIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic [CNT_BITWIDTH-1:0]  cfg_len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_BITWIDTH-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_BITWIDTH-1:0] out_data,
    output logic                     busy
);

    acc_state_e               state_q, state_d;
    logic [DATA_BITWIDTH-1:0] acc_q, acc_d;
    logic [CNT_BITWIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_BITWIDTH-1:0]  len_q, len_d;

    logic                     in_fire;
    logic                     out_fire;
    logic [CNT_BITWIDTH-1:0]  len_eff;
    logic [CNT_BITWIDTH-1:0]  cnt_inc;
    logic [1:0]               add_mode;
    logic [DATA_BITWIDTH-1:0] add_sum;

    // Outside ACCUM every accepted beat opens a new group, so the adder just
    // passes in_data through; inside ACCUM it adds onto the running sum.
    assign add_mode = (state_q == StAccum) ? ADD_MODE_SUM : ADD_MODE_PASS_RIGHT;

    basic_adder #(
        .DATA_BITWIDTH(DATA_BITWIDTH)
    ) u_adder (
        .left (acc_q),
        .right(in_data),
        .mode (add_mode),
        .sum  (add_sum)
    );

    assign len_eff = (cfg_len == '0) ? CNT_BITWIDTH'(1) : cfg_len;
    assign cnt_inc = cnt_q + CNT_BITWIDTH'(1);

    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = (state_q != StIdle);
        if (state_q == StHold) begin
            out_valid = 1'b1;
            out_data  = acc_q;
            in_ready  = out_ready;
        end
        if (clear) begin
            in_ready = 1'b0;
        end
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready & ~clear;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;

        if (clear) begin
            state_d = StIdle;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_fire) begin
                        acc_d   = add_sum;
                        cnt_d   = CNT_BITWIDTH'(1);
                        len_d   = len_eff;
                        state_d = (len_eff == CNT_BITWIDTH'(1)) ? StHold : StAccum;
                    end
                end
                StAccum: begin
                    if (in_fire) begin
                        acc_d = add_sum;
                        cnt_d = cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_d = StHold;
                        end
                    end
                end
                StHold: begin
                    if (out_fire) begin
                        // in_ready follows out_ready here, so a beat can only
                        // arrive together with the output firing.
                        if (in_fire) begin
                            acc_d   = add_sum;
                            cnt_d   = CNT_BITWIDTH'(1);
                            len_d   = len_eff;
                            state_d = (len_eff == CNT_BITWIDTH'(1)) ? StHold : StAccum;
                        end else begin
                            cnt_d   = '0;
                            state_d = StIdle;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

endmodule
